// File: rtl/mcu_cmd_ptr_pkg.sv
// Shared opcodes, constants and helpers for the MCU command pointer block.
package mcu_cmd_ptr_pkg;

  // Opcode nibbles matched against cmd_data[7:4]
  localparam logic [3:0] CMD_SETCHAN = 4'h3;
  localparam logic [3:0] CMD_SETPTR  = 4'h0;
  localparam logic [3:0] CMD_SETMASK = 4'h1;
  localparam logic [3:0] CMD_READ    = 4'h8;
  localparam logic [3:0] CMD_WRITE   = 4'h9;

  // Full-byte opcodes
  localparam logic [7:0] CMD_ECHO   = 8'hF0;
  localparam logic [7:0] CMD_STATUS = 8'hF1;

  localparam logic [7:0] ECHO_VAL = 8'hA5;

  // Status byte layout: {busy, ovf, tmo, 2'b0, chan[2:0]}
  localparam int unsigned STAT_BUSY_BIT = 7;
  localparam int unsigned STAT_OVF_BIT  = 6;
  localparam int unsigned STAT_TMO_BIT  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite
  } req_state_e;

  function automatic int unsigned addr_bytes(input int unsigned w);
    return (w + 7) / 8;
  endfunction

  function automatic logic [7:0] status_byte(input logic       busy,
                                             input logic       ovf,
                                             input logic       tmo,
                                             input logic [2:0] chan);
    logic [7:0] s;
    s                = '0;
    s[STAT_BUSY_BIT] = busy;
    s[STAT_OVF_BIT]  = ovf;
    s[STAT_TMO_BIT]  = tmo;
    s[2:0]           = chan;
    return s;
  endfunction

endpackage

// File: rtl/mcu_ptr_chan.sv
// One pointer channel: pointer and wrap mask with MSB-first byte load and
// masked +k increment. Bits outside the mask never change on increment.
module mcu_ptr_chan #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned ADDR_BYTES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ptr_ld_i,
  input  logic              mask_ld_i,
  input  logic [1:0]        ld_idx_i,
  input  logic [7:0]        ld_data_i,
  input  logic [1:0]        inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  // Byte lanes are laid out on a whole-byte padded view; bits above ADDR_W drop off
  localparam int unsigned PadW = ADDR_BYTES * 8;

  logic [ADDR_W-1:0] ptr_q, ptr_d, mask_q, mask_d;
  logic [PadW-1:0]   byte_sel, byte_val, ptr_pad, mask_pad;
  logic [1:0]        byte_pos;

  // Next pointer/mask: a load byte wins over any increment
  always_comb begin
    byte_pos = 2'(ADDR_BYTES - 1) - ld_idx_i;
    byte_sel = PadW'(8'hFF) << {byte_pos, 3'b000};
    byte_val = PadW'(ld_data_i) << {byte_pos, 3'b000};
    ptr_pad  = PadW'(ptr_q);
    mask_pad = PadW'(mask_q);
    ptr_d    = ptr_q;
    mask_d   = mask_q;
    if (ptr_ld_i) begin
      // The top byte starts a fresh pointer, so lower bits are cleared
      if (ld_idx_i == 2'd0) ptr_d = ADDR_W'(byte_val);
      else                  ptr_d = ADDR_W'((ptr_pad & ~byte_sel) | byte_val);
    end else if (!mask_ld_i && (inc_i != 2'd0)) begin
      ptr_d = (ptr_q & ~mask_q) | ((ptr_q + ADDR_W'(inc_i)) & mask_q);
    end
    if (mask_ld_i) mask_d = ADDR_W'((mask_pad & ~byte_sel) | byte_val);
  end

  // Pointer and mask registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      mask_q <= '1;
    end else begin
      ptr_q  <= ptr_d;
      mask_q <= mask_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/mcu_cmd_ptr.sv
// MCU command decoder pointer/handshake block: N_CHAN masked address pointers,
// single-outstanding read/write requests to the memory arbiter.
// Optional request watchdog: define MCU_CMD_PTR_TIMEOUT_EN.
module mcu_cmd_ptr
  import mcu_cmd_ptr_pkg::*;
#(
  parameter int unsigned N_CHAN      = 4,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_ready,
  input  logic                     param_ready,
  input  logic [7:0]               cmd_data,
  input  logic [7:0]               param_data,
  input  logic [31:0]              spi_byte_cnt,
  output logic [7:0]               spi_data_out,
  output logic                     mcu_rrq,
  output logic                     mcu_wrq,
  input  logic                     mcu_rq_rdy,
  input  logic [7:0]               mcu_data_in,
  output logic [7:0]               mcu_data_out,
  output logic [ADDR_W-1:0]        mcu_addr_out,
  output logic [2:0]               mcu_chan_out,
  input  logic                     ext_inc,
  input  logic [2:0]               ext_inc_chan,
  output logic [N_CHAN*ADDR_W-1:0] ptr_all_out,
  output logic                     busy_out
);

  localparam int unsigned ADDR_BYTES = addr_bytes(ADDR_W);

  req_state_e state_q, state_d;

  logic [2:0] chan_q, chan_d;
  logic [1:0] rdy_hist_q;
  logic [7:0] spi_q, mcu_data_q;
  logic       rrq_q, rrq_d, wrq_q, wrq_d;
  logic       ovf_q, req_drop;
  logic       busy, done, inc_done, timeout, tmo;

  logic       any_strobe, in_ld_range;
  logic [3:0] op;
  logic       set_chan, ld_ptr, ld_mask, rd_start, wr_start;
  logic       echo_hit, status_hit, status_clr;
  logic [1:0] ld_idx;

  logic [ADDR_W-1:0] ptr_arr [N_CHAN];

  // Command decode; every action is gated by its strobe
  always_comb begin
    any_strobe  = cmd_ready | param_ready;
    op          = cmd_data[7:4];
    in_ld_range = (spi_byte_cnt >= 32'd2) && (spi_byte_cnt <= 32'(ADDR_BYTES + 1));
    ld_idx      = 2'(spi_byte_cnt - 32'd2);
    set_chan    = cmd_ready && (op == CMD_SETCHAN);
    ld_ptr      = param_ready && (op == CMD_SETPTR) && in_ld_range;
    ld_mask     = param_ready && (op == CMD_SETMASK) && in_ld_range;
    rd_start    = any_strobe && (op == CMD_READ);
    wr_start    = param_ready && (op == CMD_WRITE);
    echo_hit    = any_strobe && (cmd_data == CMD_ECHO);
    status_hit  = any_strobe && (cmd_data == CMD_STATUS);
    status_clr  = status_hit && (spi_byte_cnt == 32'd2);
    if (32'(cmd_data[2:0]) >= N_CHAN) chan_d = 3'(N_CHAN - 1);
    else                               chan_d = cmd_data[2:0];
  end

  assign busy     = (state_q != StIdle);
  // Completion is one cycle after the rising edge is captured; idle ignores stray edges
  assign done     = busy && (rdy_hist_q == 2'b01);
  assign inc_done = done && cmd_data[3];

  // Request state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Request next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rd_start)      state_d = StRead;
        else if (wr_start) state_d = StWrite;
      end
      StRead, StWrite: begin
        if (done || timeout) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Request outputs: pulses only from idle; a start while busy is dropped and flagged
  always_comb begin
    rrq_d    = 1'b0;
    wrq_d    = 1'b0;
    req_drop = 1'b0;
    if (state_q == StIdle) begin
      rrq_d = rd_start;
      wrq_d = wr_start;
    end else begin
      req_drop = rd_start | wr_start;
    end
  end

  // Handshake, channel select, returned bytes and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rrq_q      <= 1'b0;
      wrq_q      <= 1'b0;
      rdy_hist_q <= 2'b00;
      chan_q     <= '0;
      mcu_data_q <= '0;
      spi_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rrq_q      <= rrq_d;
      wrq_q      <= wrq_d;
      rdy_hist_q <= {rdy_hist_q[0], mcu_rq_rdy};
      if (set_chan) chan_q <= chan_d;
      if (wrq_d) mcu_data_q <= param_data;
      if (echo_hit)        spi_q <= ECHO_VAL;
      else if (status_hit) spi_q <= status_byte(busy, ovf_q, tmo, chan_q);
      // Returned read data takes precedence over a concurrent echo/status
      if (done && (state_q == StRead)) spi_q <= mcu_data_in;
      if (status_clr) ovf_q <= 1'b0;
      if (req_drop)   ovf_q <= 1'b1;
    end
  end

`ifdef MCU_CMD_PTR_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        tmo_q;

  assign timeout = busy && !done && (tmo_cnt_q == 32'(TIMEOUT_CYC - 1));
  assign tmo     = tmo_q;

  // Watchdog: counts busy cycles, abandons the request at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      if (!busy || done || timeout) tmo_cnt_q <= '0;
      else                          tmo_cnt_q <= tmo_cnt_q + 32'd1;
      if (status_clr) tmo_q <= 1'b0;
      if (timeout)    tmo_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign tmo     = 1'b0;
`endif

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    logic       act, ext_hit;
    logic [1:0] inc_k;

    assign act     = (chan_q == 3'(c));
    // Out-of-range ext_inc_chan matches no channel and is dropped here
    assign ext_hit = ext_inc && (ext_inc_chan == 3'(c));
    assign inc_k   = {1'b0, inc_done && act} + {1'b0, ext_hit};

    mcu_ptr_chan #(
      .ADDR_W     (ADDR_W),
      .ADDR_BYTES (ADDR_BYTES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .ptr_ld_i  (ld_ptr && act),
      .mask_ld_i (ld_mask && act),
      .ld_idx_i  (ld_idx),
      .ld_data_i (param_data),
      .inc_i     (inc_k),
      .ptr_o     (ptr_arr[c])
    );

    assign ptr_all_out[c*ADDR_W +: ADDR_W] = ptr_arr[c];
  end

  // Active-channel pointer mux
  always_comb begin
    mcu_addr_out = '0;
    for (int c = 0; c < int'(N_CHAN); c++) begin
      if (chan_q == 3'(c)) mcu_addr_out = ptr_arr[c];
    end
  end

  assign spi_data_out = spi_q;
  assign mcu_rrq      = rrq_q;
  assign mcu_wrq      = wrq_q;
  assign mcu_data_out = mcu_data_q;
  assign mcu_chan_out = chan_q;
  assign busy_out     = busy;

endmodule

// File: tb/tb_mcu_cmd_ptr.sv
// Directed bench for mcu_cmd_ptr (N_CHAN=4, ADDR_W=24).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mcu_cmd_ptr;

  localparam int unsigned N_CHAN      = 4;
  localparam int unsigned ADDR_W      = 24;
  localparam int unsigned TIMEOUT_CYC = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cmd_ready, param_ready;
  logic [7:0]               cmd_data, param_data;
  logic [31:0]              spi_byte_cnt;
  logic [7:0]               spi_data_out;
  logic                     mcu_rrq, mcu_wrq, mcu_rq_rdy;
  logic [7:0]               mcu_data_in, mcu_data_out;
  logic [ADDR_W-1:0]        mcu_addr_out;
  logic [2:0]               mcu_chan_out;
  logic                     ext_inc;
  logic [2:0]               ext_inc_chan;
  logic [N_CHAN*ADDR_W-1:0] ptr_all_out;
  logic                     busy_out;

  int n_checks = 0;
  int n_errors = 0;

  mcu_cmd_ptr #(
    .N_CHAN      (N_CHAN),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_ready    (cmd_ready),
    .param_ready  (param_ready),
    .cmd_data     (cmd_data),
    .param_data   (param_data),
    .spi_byte_cnt (spi_byte_cnt),
    .spi_data_out (spi_data_out),
    .mcu_rrq      (mcu_rrq),
    .mcu_wrq      (mcu_wrq),
    .mcu_rq_rdy   (mcu_rq_rdy),
    .mcu_data_in  (mcu_data_in),
    .mcu_data_out (mcu_data_out),
    .mcu_addr_out (mcu_addr_out),
    .mcu_chan_out (mcu_chan_out),
    .ext_inc      (ext_inc),
    .ext_inc_chan (ext_inc_chan),
    .ptr_all_out  (ptr_all_out),
    .busy_out     (busy_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmd_strobe(input logic [7:0] b, input int cnt);
    cmd_data     = b;
    spi_byte_cnt = 32'(cnt);
    cmd_ready    = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic param_strobe(input logic [7:0] b, input int cnt);
    param_data   = b;
    spi_byte_cnt = 32'(cnt);
    param_ready  = 1'b1;
    @(negedge clk);
    param_ready = 1'b0;
  endtask

  // Command byte then three parameter bytes, MSB first
  task automatic load3(input logic [7:0] op, input logic [23:0] v);
    cmd_strobe(op, 1);
    param_strobe(v[23:16], 2);
    param_strobe(v[15:8], 3);
    param_strobe(v[7:0], 4);
  endtask

  task automatic ext_pulse(input logic [2:0] ch);
    ext_inc      = 1'b1;
    ext_inc_chan = ch;
    @(negedge clk);
    ext_inc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    cmd_ready    = 1'b0;
    param_ready  = 1'b0;
    cmd_data     = 8'h00;
    param_data   = 8'h00;
    spi_byte_cnt = 32'd0;
    mcu_rq_rdy   = 1'b0;
    mcu_data_in  = 8'h00;
    ext_inc      = 1'b0;
    ext_inc_chan = 3'd0;
    repeat (2) @(negedge clk);

    check("rst_spi", spi_data_out, 8'h00);
    check("rst_busy", busy_out, 1'b0);
    check("rst_chan", mcu_chan_out, 3'd0);
    check("rst_ptrs", ptr_all_out, 96'h0);
    check("rst_rrq", mcu_rrq, 1'b0);
    check("rst_wrq", mcu_wrq, 1'b0);
    check("rst_wdata", mcu_data_out, 8'h00);
    rst = 1'b0;

    // Channel select and pointer load
    cmd_strobe(8'h32, 1);
    check("setchan", mcu_chan_out, 3'd2);
    load3(8'h00, 24'h123456);
    check("setptr_addr", mcu_addr_out, 24'h123456);
    check("setptr_all", ptr_all_out, {24'h0, 24'h123456, 24'h0, 24'h0});

    // Masked read with increment
    load3(8'h10, 24'h0000FF);
    load3(8'h00, 24'h1234FF);
    check("ptr_1234ff", mcu_addr_out, 24'h1234FF);
    cmd_strobe(8'h88, 1);
    check("rd_rrq_hi", mcu_rrq, 1'b1);
    check("rd_busy", busy_out, 1'b1);
    @(negedge clk);
    check("rd_rrq_lo", mcu_rrq, 1'b0);
    mcu_data_in = 8'h5A;
    mcu_rq_rdy  = 1'b1;
    @(negedge clk);
    check("rd_busy_hold", busy_out, 1'b1);
    @(negedge clk);
    check("rd_data", spi_data_out, 8'h5A);
    check("rd_wrap", mcu_addr_out, 24'h123400);
    check("rd_wrap_all", ptr_all_out[71:48], 24'h123400);
    check("rd_idle", busy_out, 1'b0);
    mcu_rq_rdy = 1'b0;
    @(negedge clk);

    // Overlapping start while busy sets ovf
    cmd_strobe(8'h80, 1);
    check("ovf_rrq1", mcu_rrq, 1'b1);
    param_strobe(8'h00, 2);
    check("ovf_no_rrq", mcu_rrq, 1'b0);
    check("ovf_busy", busy_out, 1'b1);
    mcu_data_in = 8'h77;
    mcu_rq_rdy  = 1'b1;
    repeat (2) @(negedge clk);
    check("ovf_done", busy_out, 1'b0);
    check("ovf_rdata", spi_data_out, 8'h77);
    check("ovf_noinc", mcu_addr_out, 24'h123400);
    mcu_rq_rdy = 1'b0;
    @(negedge clk);
    cmd_strobe(8'hF1, 1);
    check("stat_cmd", spi_data_out, 8'h42);
    param_strobe(8'h00, 2);
    check("stat_idx2", spi_data_out, 8'h42);
    param_strobe(8'h00, 3);
    check("stat_cleared", spi_data_out, 8'h02);

    cmd_strobe(8'hF0, 1);
    check("echo", spi_data_out, 8'hA5);

    // Write with ext_inc landing on the done cycle: +2
    cmd_strobe(8'h98, 1);
    check("wr_cmd_nowrq", mcu_wrq, 1'b0);
    param_strobe(8'hC3, 2);
    check("wr_wrq_hi", mcu_wrq, 1'b1);
    check("wr_data", mcu_data_out, 8'hC3);
    check("wr_busy", busy_out, 1'b1);
    @(negedge clk);
    check("wr_wrq_lo", mcu_wrq, 1'b0);
    mcu_rq_rdy = 1'b1;
    @(negedge clk);
    ext_pulse(3'd2);
    check("wr_inc2", mcu_addr_out, 24'h123402);
    check("wr_idle", busy_out, 1'b0);
    check("wr_spi_keep", spi_data_out, 8'hA5);
    mcu_rq_rdy = 1'b0;
    @(negedge clk);

    // External increment, out-of-range channel, channel clamp
    ext_pulse(3'd0);
    check("ext_ch0", ptr_all_out[23:0], 24'h000001);
    ext_pulse(3'd5);
    check("ext_oor", ptr_all_out, {24'h0, 24'h123402, 24'h0, 24'h000001});
    cmd_strobe(8'h37, 1);
    check("clamp", mcu_chan_out, 3'd3);

    // Load byte beats a same-cycle increment
    cmd_strobe(8'h00, 1);
    param_data   = 8'hAB;
    spi_byte_cnt = 32'd2;
    param_ready  = 1'b1;
    ext_pulse(3'd3);
    param_ready = 1'b0;
    check("ld_prio", mcu_addr_out, 24'hAB0000);

    // Reset while busy, then a late ready edge
    cmd_strobe(8'h88, 1);
    check("rb_busy", busy_out, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rb_busy0", busy_out, 1'b0);
    check("rb_ptrs", ptr_all_out, 96'h0);
    check("rb_chan", mcu_chan_out, 3'd0);
    mcu_rq_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rb_late_ptrs", ptr_all_out, 96'h0);
    check("rb_late_busy", busy_out, 1'b0);
    check("rb_late_spi", spi_data_out, 8'h00);
    mcu_rq_rdy = 1'b0;
    @(negedge clk);
    cmd_strobe(8'h32, 1);
    load3(8'h00, 24'h00FFFF);
    ext_pulse(3'd2);
    check("rb_mask_ones", mcu_addr_out, 24'h010000);

`ifdef MCU_CMD_PTR_TIMEOUT_EN
    cmd_strobe(8'h88, 1);
    check("to_rrq", mcu_rrq, 1'b1);
    repeat (15) @(negedge clk);
    check("to_busy15", busy_out, 1'b1);
    @(negedge clk);
    check("to_busy16", busy_out, 1'b0);
    check("to_spi_keep", spi_data_out, 8'h00);
    check("to_noinc", mcu_addr_out, 24'h010000);
    cmd_strobe(8'hF1, 1);
    check("to_status", spi_data_out, 8'h22);
    mcu_rq_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("to_late_ptr", mcu_addr_out, 24'h010000);
    check("to_late_spi", spi_data_out, 8'h22);
    mcu_rq_rdy = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
